// File: rtl/branch_imm_encoder.sv
// branch_imm_encoder
//   Converts a branch PC and an absolute target address into the 24-bit signed
//   word-offset field of a B/BL instruction. This is the inverse of the decode
//   path, which sign-extends imm24 and shifts it left by two.
//   The datapath is a two-stage valid/ready pipeline:
//     stage 1 - captures the byte offset diff = target - pc - PC_OFFSET (mod 2^32)
//     stage 2 - slices imm24 out of diff and flags misalignment and range overflow
//   A saturating counter tracks how many delivered results carried an error flag.

module branch_imm_encoder #(
   parameter int unsigned PC_OFFSET = 8,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      pc,
   input  logic [31:0]      target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [23:0]      imm24,
   output logic             misaligned,
   output logic             out_of_range,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [31:0] PC_OFF_C = 32'(PC_OFFSET);

   // The offset is legal only when bits [31:25] are a pure sign extension of bit 25.
   function automatic logic offset_out_of_range(input logic [31:0] diff);
      logic all_zero;
      logic all_one;
      all_zero = (diff[31:25] == 7'b000_0000);
      all_one  = (diff[31:25] == 7'b111_1111);
      return ~(all_zero | all_one);
   endfunction

   // A branch target must be word aligned relative to the architectural PC.
   function automatic logic offset_misaligned(input logic [31:0] diff);
      return |diff[1:0];
   endfunction

   // Pipeline state
   logic             s1_valid_q, s1_valid_d;
   logic [31:0]      s1_diff_q,  s1_diff_d;
   logic             s2_valid_q, s2_valid_d;
   logic [23:0]      imm24_q,    imm24_d;
   logic             mis_q,      mis_d;
   logic             oor_q,      oor_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

   // Handshake signals
   logic             adv1_s;
   logic             adv2_s;
   logic             out_xfer_s;
   logic             out_err_s;
   logic             err_sat_s;

   // Advance conditions: a stage may load when it is empty or its consumer drains it.
   always_comb begin
      adv2_s     = (~s2_valid_q) | out_ready;
      adv1_s     = (~s1_valid_q) | adv2_s;
      out_xfer_s = s2_valid_q & out_ready;
      out_err_s  = mis_q | oor_q;
      err_sat_s  = &err_cnt_q;
   end

   // Stage 1 next state: accept a new pc/target pair, or a bubble, whenever it advances.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_diff_d  = s1_diff_q;
      if (adv1_s) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_diff_d = target - pc - PC_OFF_C;
         end else begin
            s1_diff_d = s1_diff_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // Stage 2 next state: slice the field and compute flags from the stage-1 offset.
   always_comb begin
      s2_valid_d = s2_valid_q;
      imm24_d    = imm24_q;
      mis_d      = mis_q;
      oor_d      = oor_q;
      if (adv2_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            // The field is always the truncated offset, even when a flag is raised.
            imm24_d = s1_diff_q[25:2];
            mis_d   = offset_misaligned(s1_diff_q);
            oor_d   = offset_out_of_range(s1_diff_q);
         end else begin
            imm24_d = imm24_q;
            mis_d   = mis_q;
            oor_d   = oor_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Error counter next state: clear wins over a concurrent increment; saturates at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = {CNT_W{1'b0}};
      end else if (out_xfer_s && out_err_s && !err_sat_s) begin
         err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State registers with synchronous active-low reset; in-flight data is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_diff_q  <= 32'h0000_0000;
         s2_valid_q <= 1'b0;
         imm24_q    <= 24'h00_0000;
         mis_q      <= 1'b0;
         oor_q      <= 1'b0;
         err_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_diff_q  <= s1_diff_d;
         s2_valid_q <= s2_valid_d;
         imm24_q    <= imm24_d;
         mis_q      <= mis_d;
         oor_q      <= oor_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // in_ready is combinational from out_ready because there is no skid buffer.
   assign in_ready     = adv1_s;
   assign out_valid    = s2_valid_q;
   assign imm24        = imm24_q;
   assign misaligned   = mis_q;
   assign out_of_range = oor_q;
   assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_branch_imm_encoder.sv
// Directed testbench for branch_imm_encoder.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_branch_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc;
   logic [31:0] target;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] imm24;
   logic        misaligned;
   logic        out_of_range;
   logic        err_clr;
   logic [15:0] err_count;

   int n_tests;
   int n_fail;

   branch_imm_encoder #(.PC_OFFSET(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .pc           (pc),
      .target       (target),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .imm24        (imm24),
      .misaligned   (misaligned),
      .out_of_range (out_of_range),
      .err_clr      (err_clr),
      .err_count    (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One item through an otherwise idle pipeline with out_ready held high.
   // Starts and ends on a falling edge; the result's out transfer is completed.
   task automatic single(input string tag, input logic [31:0] p, input logic [31:0] t,
                         input logic [23:0] e_imm, input logic e_mis, input logic e_oor,
                         input logic clr);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      pc        = p;
      target    = t;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check({tag, " valid@1"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      check({tag, " valid@2"}, {31'd0, out_valid}, 32'd1);
      check({tag, " imm24"}, {8'd0, imm24}, {8'd0, e_imm});
      check({tag, " flags"}, {30'd0, misaligned, out_of_range}, {30'd0, e_mis, e_oor});
      err_clr = clr;
      @(posedge clk); @(negedge clk);
      err_clr = 1'b0;
   endtask

   // Stream vectors: pc, target, expected {misaligned, out_of_range, imm24}
   logic [31:0] v_pc  [8];
   logic [31:0] v_tgt [8];
   logic [25:0] v_exp [8];
   logic [15:0] rdy_pat;

   initial begin
      v_pc[0] = 32'h0000_1000; v_tgt[0] = 32'h0000_1008; v_exp[0] = {2'b00, 24'h000000};
      v_pc[1] = 32'h0000_1000; v_tgt[1] = 32'h0000_0000; v_exp[1] = {2'b00, 24'hFFFBFE};
      v_pc[2] = 32'h0000_1000; v_tgt[2] = 32'h0000_1000; v_exp[2] = {2'b00, 24'hFFFFFE};
      v_pc[3] = 32'h0000_0000; v_tgt[3] = 32'h0200_0004; v_exp[3] = {2'b00, 24'h7FFFFF};
      v_pc[4] = 32'h0000_0000; v_tgt[4] = 32'h0200_0008; v_exp[4] = {2'b01, 24'h800000};
      v_pc[5] = 32'h0000_0000; v_tgt[5] = 32'hFE00_0008; v_exp[5] = {2'b00, 24'h800000};
      v_pc[6] = 32'h0000_1000; v_tgt[6] = 32'h0000_100A; v_exp[6] = {2'b10, 24'h000000};
      v_pc[7] = 32'h0000_2000; v_tgt[7] = 32'h0000_2108; v_exp[7] = {2'b00, 24'h000040};
      rdy_pat = 16'b1011_0010_0111_0001;
   end

   initial begin
      logic [25:0] exp_q[$];
      logic        m_s1, m_s2, a1, a2;
      logic        stalled;
      logic [25:0] held;
      int          sent, rcvd, cyc;

      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      pc        = 32'd0;
      target    = 32'd0;
      err_clr   = 1'b0;

      // Reset state
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst in_ready",  {31'd0, in_ready},  32'd1);
      check("rst imm24",     {8'd0, imm24},      32'd0);
      check("rst flags",     {30'd0, misaligned, out_of_range}, 32'd0);
      check("rst err_count", {16'd0, err_count}, 32'd0);

      // Basic encodes and range edges
      single("t1",       32'h0000_1000, 32'h0000_1008, 24'h000000, 1'b0, 1'b0, 1'b0);
      single("t2 back",  32'h0000_1000, 32'h0000_0000, 24'hFFFBFE, 1'b0, 1'b0, 1'b0);
      single("t2 self",  32'h0000_1000, 32'h0000_1000, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
      single("t3 maxp",  32'h0000_0000, 32'h0200_0004, 24'h7FFFFF, 1'b0, 1'b0, 1'b0);
      single("t3 overp", 32'h0000_0000, 32'h0200_0008, 24'h800000, 1'b0, 1'b1, 1'b0);
      single("t3 maxn",  32'h0000_0000, 32'hFE00_0008, 24'h800000, 1'b0, 1'b0, 1'b0);
      single("t3 overn", 32'h0000_0000, 32'hFE00_0004, 24'h7FFFFF, 1'b0, 1'b1, 1'b0);
      check("cnt after range", {16'd0, err_count}, 32'd2);

      // Clear, then count misaligned results; clear beats a concurrent increment
      err_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      err_clr = 1'b0;
      check("cnt cleared", {16'd0, err_count}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         single("t4 mis", 32'h0000_1000, 32'h0000_100A, 24'h000000, 1'b1, 1'b0, 1'b0);
      end
      check("cnt 3 errors", {16'd0, err_count}, 32'd3);
      single("t4 clr", 32'h0000_1000, 32'h0000_100A, 24'h000000, 1'b1, 1'b0, 1'b1);
      check("cnt clr wins", {16'd0, err_count}, 32'd0);

      // Streaming with a fixed backpressure pattern
      m_s1 = 1'b0; m_s2 = 1'b0; stalled = 1'b0; held = 26'd0;
      sent = 0; rcvd = 0; cyc = 0;
      while (rcvd < 8 && cyc < 200) begin
         if (stalled) begin
            check("t5 stable valid", {31'd0, out_valid}, 32'd1);
            check("t5 stable data", {6'd0, misaligned, out_of_range, imm24}, {6'd0, held});
         end
         check("t5 out_valid", {31'd0, out_valid}, {31'd0, m_s2});
         out_ready = rdy_pat[cyc % 16];
         in_valid  = (sent < 8);
         if (sent < 8) begin
            pc = v_pc[sent]; target = v_tgt[sent];
         end else begin
            pc = 32'd0; target = 32'd0;
         end
         #1;
         check("t5 in_ready", {31'd0, in_ready}, {31'd0, (~m_s1) | (~m_s2) | out_ready});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("t5 extra output", 32'd1, 32'd0);
            end else begin
               check("t5 data", {6'd0, misaligned, out_of_range, imm24}, {6'd0, exp_q.pop_front()});
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(v_exp[sent]);
            sent++;
         end
         stalled = out_valid & ~out_ready;
         held    = {misaligned, out_of_range, imm24};
         a2   = ~m_s2 | out_ready;
         a1   = ~m_s1 | a2;
         m_s2 = a2 ? m_s1 : m_s2;
         m_s1 = a1 ? in_valid : m_s1;
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check("t5 received", rcvd, 32'd8);
      check("t5 cnt", {16'd0, err_count}, 32'd2);

      // Reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1; pc = 32'h0000_0000; target = 32'h0000_0003;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      check("t6 full in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      check("t6 out_valid", {31'd0, out_valid}, 32'd0);
      check("t6 in_ready",  {31'd0, in_ready},  32'd1);
      check("t6 err_count", {16'd0, err_count}, 32'd0);
      single("t6 post", 32'h0000_2000, 32'h0000_2108, 24'h000040, 1'b0, 1'b0, 1'b0);
      check("t6 empty", {31'd0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
